// File: rtl/touch_scan_sequencer.sv
// Autonomous ADS7843-style X/Y scan master for the touch SPI core register port.
// Latency: one X/Y sample every INTERVAL_CYCLES; each register access is 3 clk (2 strobe + 1 gap).
// Backpressure: polls core TRDY/RRDY; after POLL_LIMIT failed polls it releases SS and flags timeout_err.
module touch_scan_sequencer #(
    parameter logic [7:0] CMD_X           = 8'hD0,
    parameter logic [7:0] CMD_Y           = 8'h90,
    parameter int         INTERVAL_CYCLES = 500000,
    parameter int         POLL_LIMIT      = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        pen_irq_n,
    output logic        spi_select,
    output logic [2:0]  spi_addr,
    output logic [15:0] spi_wdata,
    output logic        spi_read_n,
    output logic        spi_write_n,
    input  logic [15:0] spi_rdata,
    output logic        sample_valid,
    output logic [11:0] x_pos,
    output logic [11:0] y_pos,
    output logic        busy,
    output logic        timeout_err
);
    localparam int IW = $clog2(INTERVAL_CYCLES);
    localparam int PW = $clog2(POLL_LIMIT + 1);
    localparam logic [IW-1:0] IVAL_LAST = IW'(INTERVAL_CYCLES - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_SS_ON, S_POLL_T, S_WR_TX, S_POLL_R, S_RD_RX, S_SS_OFF, S_DONE, S_WAIT
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      phase;      // 0,1: strobe cycles; 2: idle gap
    logic [PW-1:0]   poll_cnt;
    logic [IW-1:0]   ival_cnt;
    logic            axis;       // 0 = X, 1 = Y
    logic [1:0]      byte_idx;
    logic [7:0]      rx_cap;
    logic [6:0]      x_hi, y_hi;
    logic [4:0]      x_lo, y_lo;
    logic            aborting;
    logic            pen_s1, pen_s2, enable_d;
    logic            pen_down, acc_state, acc_end, timeout_hit, ss_on_entry;
    logic            unused_rdata_hi;

    assign unused_rdata_hi = ^spi_rdata[15:8];
    assign pen_down        = ~pen_s2;
    assign acc_state       = (state == S_SS_ON) || (state == S_POLL_T) || (state == S_WR_TX) ||
                             (state == S_POLL_R) || (state == S_RD_RX) || (state == S_SS_OFF);
    assign acc_end         = acc_state && (phase == 2'd2);
    assign ss_on_entry     = (state_nxt == S_SS_ON) && (state != S_SS_ON);
    assign busy            = acc_state;
    assign sample_valid    = (state == S_DONE);

    // Two-flop synchroniser for the panel pen-down line, plus enable history for edge detect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pen_s1   <= 1'b1;
            pen_s2   <= 1'b1;
            enable_d <= 1'b0;
        end else begin
            pen_s1   <= pen_irq_n;
            pen_s2   <= pen_s1;
            enable_d <= enable;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic and register-port bus outputs.
    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        spi_select  = 1'b0;
        spi_addr    = 3'd0;
        spi_wdata   = 16'h0000;
        spi_read_n  = 1'b1;
        spi_write_n = 1'b1;
        if (acc_state && phase != 2'd2) begin
            spi_select = 1'b1;
            case (state)
                S_SS_ON:  begin spi_addr = 3'd3; spi_wdata = 16'h0400; spi_write_n = 1'b0; end
                S_WR_TX:  begin
                    spi_addr    = 3'd1;
                    spi_wdata   = {8'h00, (byte_idx == 2'd0) ? (axis ? CMD_Y : CMD_X) : 8'h00};
                    spi_write_n = 1'b0;
                end
                S_RD_RX:  begin spi_addr = 3'd0; spi_read_n = 1'b0; end
                S_SS_OFF: begin spi_addr = 3'd3; spi_wdata = 16'h0000; spi_write_n = 1'b0; end
                default:  begin spi_addr = 3'd2; spi_read_n = 1'b0; end
            endcase
        end
        case (state)
            S_IDLE:   if (enable && pen_down) state_nxt = S_SS_ON;
            S_SS_ON:  if (acc_end) state_nxt = S_POLL_T;
            S_POLL_T: if (acc_end) begin
                if (rx_cap[6]) state_nxt = S_WR_TX;
                else if (poll_cnt == POLL_LAST) begin state_nxt = S_SS_OFF; timeout_hit = 1'b1; end
            end
            S_WR_TX:  if (acc_end) state_nxt = S_POLL_R;
            S_POLL_R: if (acc_end) begin
                if (rx_cap[7]) state_nxt = S_RD_RX;
                else if (poll_cnt == POLL_LAST) begin state_nxt = S_SS_OFF; timeout_hit = 1'b1; end
            end
            S_RD_RX:  if (acc_end) state_nxt = (axis && byte_idx == 2'd2) ? S_SS_OFF : S_POLL_T;
            S_SS_OFF: if (acc_end) state_nxt = aborting ? S_IDLE : S_DONE;
            S_DONE:   state_nxt = S_WAIT;
            S_WAIT:   if (ival_cnt == IVAL_LAST) state_nxt = (enable && pen_down) ? S_SS_ON : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Access phasing, poll/interval counters, byte capture and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase       <= 2'd0;
            poll_cnt    <= '0;
            ival_cnt    <= '0;
            axis        <= 1'b0;
            byte_idx    <= 2'd0;
            rx_cap      <= 8'h00;
            x_hi        <= 7'd0;
            x_lo        <= 5'd0;
            y_hi        <= 7'd0;
            y_lo        <= 5'd0;
            aborting    <= 1'b0;
            x_pos       <= 12'd0;
            y_pos       <= 12'd0;
            timeout_err <= 1'b0;
        end else begin
            phase <= (acc_state && phase != 2'd2) ? phase + 2'd1 : 2'd0;
            if (acc_state && phase == 2'd1) rx_cap <= spi_rdata[7:0];

            if (state_nxt != state) poll_cnt <= '0;
            else if (acc_end && (state == S_POLL_T || state == S_POLL_R)) poll_cnt <= poll_cnt + PW'(1);

            // Free-running from SS_ON entry, saturating so a long sample never wraps.
            if (ss_on_entry) ival_cnt <= '0;
            else if (ival_cnt != IVAL_LAST) ival_cnt <= ival_cnt + IW'(1);

            if (ss_on_entry) begin
                axis     <= 1'b0;
                byte_idx <= 2'd0;
                aborting <= 1'b0;
            end else if (timeout_hit) begin
                aborting <= 1'b1;
            end else if (state == S_RD_RX && acc_end) begin
                // Byte 0 is the turnaround byte and carries no data.
                if (byte_idx == 2'd1) begin
                    if (axis) y_hi <= rx_cap[6:0];
                    else      x_hi <= rx_cap[6:0];
                end
                if (byte_idx == 2'd2) begin
                    if (axis) y_lo <= rx_cap[7:3];
                    else      x_lo <= rx_cap[7:3];
                    axis     <= 1'b1;
                    byte_idx <= 2'd0;
                end else begin
                    byte_idx <= byte_idx + 2'd1;
                end
            end

            if (state == S_SS_OFF && acc_end && !aborting) begin
                x_pos <= {x_hi, x_lo};
                y_pos <= {y_hi, y_lo};
            end

            if (timeout_hit)              timeout_err <= 1'b1;
            else if (enable && !enable_d) timeout_err <= 1'b0;
        end
    end
endmodule
